// File: rtl/interleaver_commutator.sv
// Input/output commutator for a convolutional byte interleaver.
// It aligns to the transport-stream sync byte and steps a branch pointer on each accepted byte.
// It drives a one-hot shift enable to the external branch delay lines. The selected branch
// output is muxed into a registered interleaved byte stream.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     in_data valid this cycle (no backpressure)
//   in_data      input byte
//   buf_en       one-hot delay-line shift enable (combinational, bit 0 always 0)
//   buf_din      byte broadcast to the delay lines (combinational, = in_data)
//   branch_dout  flattened delay-line outputs, branch k at [k*W +: W]
//   out_valid    interleaved byte valid (registered)
//   out_data     interleaved byte (registered)
//   locked       high while sync lock is held
//   sync_err     one-cycle pulse on a bad sync byte while locked
module interleaver_commutator #(
  parameter int unsigned   BRANCHES  = 12,
  parameter int unsigned   W         = 8,
  parameter int unsigned   PKT_LEN   = 204,
  parameter logic [W-1:0]  SYNC_BYTE = 8'h47,
  parameter int unsigned   MISS_MAX  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_data,
  output logic [BRANCHES-1:0]   buf_en,
  output logic [W-1:0]          buf_din,
  input  logic [BRANCHES*W-1:0] branch_dout,
  output logic                  out_valid,
  output logic [W-1:0]          out_data,
  output logic                  locked,
  output logic                  sync_err
);

  localparam int unsigned PTR_W  = $clog2(BRANCHES);
  localparam int unsigned CNT_W  = $clog2(PKT_LEN);
  localparam int unsigned MISS_W = $clog2(MISS_MAX + 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                out_valid_q, out_valid_d;
  logic [W-1:0]        out_data_q, out_data_d;
  logic                sync_err_q, sync_err_d;
  logic [W-1:0]        sel_dout;
  logic                ptr_last, cnt_last, cnt_zero;

  // Pre-edge output of the currently selected branch line
  assign sel_dout = branch_dout[32'(ptr_q) * W +: W];

  assign ptr_last = (ptr_q == PTR_W'(BRANCHES - 1));
  assign cnt_last = (cnt_q == CNT_W'(PKT_LEN - 1));
  assign cnt_zero = (cnt_q == '0);

  assign buf_din   = in_data;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign locked    = (state_q == LOCK);
  assign sync_err  = sync_err_q;

  // Shift enable for the active branch; branch 0 has no delay line
  always_comb begin
    buf_en = '0;
    if (in_valid && (state_q == LOCK) && (ptr_q != '0)) begin
      buf_en[ptr_q] = 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    miss_d      = miss_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    sync_err_d  = 1'b0;

    case (state_q)
      HUNT: begin
        // The sync byte found here is packet byte 0 on branch 0
        if (in_valid && (in_data == SYNC_BYTE)) begin
          state_d     = LOCK;
          out_valid_d = 1'b1;
          out_data_d  = SYNC_BYTE;
          ptr_d       = PTR_W'(1);
          cnt_d       = CNT_W'(1);
          miss_d      = '0;
        end
      end
      LOCK: begin
        if (in_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = (ptr_q == '0) ? in_data : sel_dout;
          ptr_d       = ptr_last ? '0 : PTR_W'(ptr_q + 1'b1);
          cnt_d       = cnt_last ? '0 : CNT_W'(cnt_q + 1'b1);
          if (cnt_zero) begin
            if (in_data == SYNC_BYTE) begin
              miss_d = '0;
            end else begin
              sync_err_d = 1'b1;
              // Lock is dropped after this byte is still output normally
              if (miss_q == MISS_W'(MISS_MAX - 1)) begin
                state_d = HUNT;
                ptr_d   = '0;
                cnt_d   = '0;
                miss_d  = '0;
              end else begin
                miss_d = MISS_W'(miss_q + 1'b1);
              end
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      ptr_q       <= '0;
      cnt_q       <= '0;
      miss_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sync_err_q  <= sync_err_d;
    end
  end

endmodule
